// File: rtl/kb_matrix_scan.sv
// Key matrix scanner: walks an active-low column strobe, samples the row pins at the end of
// each column dwell, and debounces press/release into a held row vector with strobes.
module kb_matrix_scan #(
    parameter int ROWS     = 5,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 5000,
    parameter int DEBOUNCE = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ROWS-1:0]         row_in,
    output logic [COLS-1:0]         col_out,
    output logic [ROWS-1:0]         k_row,
    output logic [$clog2(COLS)-1:0] k_col,
    output logic                    key_valid,
    output logic                    key_release,
    output logic                    key_held
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(COLS);
    localparam int NW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [NW-1:0] DB_N     = NW'(DEBOUNCE);

    typedef enum logic [1:0] {S_SCAN, S_CONFIRM, S_HELD} state_t;

    state_t          state_q, state_d;
    logic [ROWS-1:0] sync1_q, sync2_q;
    logic [DW-1:0]   div_q, div_d;
    logic [CW-1:0]   col_q, col_d, col_next;
    logic [ROWS-1:0] pat_q, pat_d;
    logic [NW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [ROWS-1:0] k_row_q, k_row_d;
    logic [CW-1:0]   k_col_q, k_col_d;
    logic            valid_q, valid_d;
    logic            release_q, release_d;
    logic [ROWS-1:0] rows_s;
    logic            dwell_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_SCAN;
            sync1_q   <= '1;
            sync2_q   <= '1;
            div_q     <= '0;
            col_q     <= '0;
            pat_q     <= '0;
            cnt_q     <= '0;
            k_row_q   <= '0;
            k_col_q   <= '0;
            valid_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= row_in;
            sync2_q   <= sync1_q;
            div_q     <= div_d;
            col_q     <= col_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            k_row_q   <= k_row_d;
            k_col_q   <= k_col_d;
            valid_q   <= valid_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        rows_s    = ~sync2_q;
        dwell_end = (div_q == DIV_LAST);
        div_d     = dwell_end ? '0 : div_q + DW'(1);
        col_next  = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
        cnt_inc   = cnt_q + NW'(1);
        state_d   = state_q;
        col_d     = col_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        k_row_d   = k_row_q;
        k_col_d   = k_col_q;
        valid_d   = 1'b0;
        release_d = 1'b0;

        case (state_q)
            S_SCAN: begin
                if (dwell_end) begin
                    if (rows_s == '0) begin
                        col_d = col_next;
                    end else if (DEBOUNCE == 1) begin
                        // A single matching sample is already enough to accept.
                        pat_d   = rows_s;
                        k_row_d = rows_s;
                        k_col_d = col_q;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = S_HELD;
                    end else begin
                        pat_d   = rows_s;
                        cnt_d   = NW'(1);
                        state_d = S_CONFIRM;
                    end
                end
            end
            S_CONFIRM: begin
                if (dwell_end) begin
                    if (rows_s == pat_q) begin
                        if (cnt_inc == DB_N) begin
                            k_row_d = pat_q;
                            k_col_d = col_q;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                            state_d = S_HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_next;
                        state_d = S_SCAN;
                    end
                end
            end
            S_HELD: begin
                // Pattern changes while held are ignored; only a full release counts.
                if (dwell_end) begin
                    if (rows_s == '0) begin
                        if (cnt_inc == DB_N) begin
                            k_row_d   = '0;
                            release_d = 1'b1;
                            cnt_d     = '0;
                            col_d     = col_next;
                            state_d   = S_SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = S_SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        col_out        = '1;
        col_out[col_q] = 1'b0;
    end

    assign k_row       = k_row_q;
    assign k_col       = k_col_q;
    assign key_valid   = valid_q;
    assign key_release = release_q;
    assign key_held    = (state_q == S_HELD);
endmodule

// File: tb/tb_kb_matrix_scan.sv
// Bench for kb_matrix_scan: emulates a key matrix on the column strobes and checks
// strobes against a scoreboard of expected press/release events.
module tb_kb_matrix_scan;
    logic       clk;
    logic       rst_n;
    logic [4:0] row_in;
    logic [3:0] col_out;
    logic [4:0] k_row;
    logic [1:0] k_col;
    logic       key_valid;
    logic       key_release;
    logic       key_held;

    logic [3:0][4:0] keys;

    typedef struct {
        bit         rel;
        logic [4:0] row;
        logic [1:0] col;
    } ev_t;
    ev_t sb[$];

    int n_chk = 0;
    int n_err = 0;

    kb_matrix_scan #(.ROWS(5), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
        .k_row(k_row), .k_col(k_col), .key_valid(key_valid),
        .key_release(key_release), .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed keys pull their row low only while their column is driven.
    always_comb begin
        row_in = 5'h1F;
        for (int c = 0; c < 4; c++)
            if (!col_out[c]) row_in = row_in & ~keys[c];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_ev(input bit rel, input logic [4:0] row, input logic [1:0] col);
        ev_t e;
        e.rel = rel;
        e.row = row;
        e.col = col;
        sb.push_back(e);
    endtask

    task automatic wait_col(input logic [3:0] c, input int lim, output int n);
        n = 0;
        while (col_out !== c && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("wait_col", 32'(col_out), 32'(c));
    endtask

    task automatic wait_strobe(input bit rel, input int lim, output int n);
        logic s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            s = rel ? key_release : key_valid;
        end while (!s && n < lim);
        chk(rel ? "wait_release" : "wait_valid", 32'(s), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && (key_valid || key_release)) begin
            chk("strobe_excl", 32'(key_valid & key_release), 32'd0);
            if (sb.size() == 0) begin
                chk("unexp_strobe", 32'(sb.size()), 32'd1);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("ev_kind", 32'(key_release), 32'(e.rel));
                chk("ev_row", 32'(k_row), 32'(e.row));
                if (!e.rel) chk("ev_col", 32'(k_col), 32'(e.col));
            end
        end
    end

    initial begin
        int n;
        logic [3:0] ec;
        keys  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(col_out), 32'hE);
        chk("rst_krow", 32'(k_row), 32'h0);
        chk("rst_kcol", 32'(k_col), 32'h0);
        chk("rst_strobes", 32'({key_valid, key_release, key_held}), 32'h0);

        // Idle scan: each column driven for 4 cycles.
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ec = 4'hF;
            ec[(i / 4) % 4] = 1'b0;
            chk("idle_col", 32'(col_out), 32'(ec));
            @(negedge clk);
        end
        chk("idle_krow", 32'(k_row), 32'h0);

        // Steady press on col1/row2.
        keys[1][2] = 1'b1;
        push_ev(1'b0, 5'b00100, 2'd1);
        wait_col(4'b1101, 40, n);
        wait_strobe(1'b0, 40, n);
        chk("press_latency", 32'(n), 32'd12);
        chk("press_held", 32'(key_held), 32'd1);
        repeat (8) @(negedge clk);
        chk("held_col", 32'(col_out), 32'b1101);
        keys[1][0] = 1'b1;
        repeat (12) @(negedge clk);
        chk("held_krow_frozen", 32'(k_row), 32'b00100);
        chk("held_level", 32'(key_held), 32'd1);
        keys[1] = '0;
        push_ev(1'b1, 5'b0, 2'd0);
        wait_strobe(1'b1, 40, n);
        chk("rel_krow", 32'(k_row), 32'h0);
        chk("rel_held", 32'(key_held), 32'd0);
        chk("rel_col", 32'(col_out), 32'b1011);

        // Bounce: one dwell only.
        wait_col(4'b1101, 40, n);
        keys[1][2] = 1'b1;
        repeat (4) @(negedge clk);
        keys[1] = '0;
        wait_col(4'b1011, 40, n);
        chk("bounce_adv", 32'(n + 4), 32'd8);
        chk("bounce_krow", 32'(k_row), 32'h0);

        // Two matching dwells is one short of acceptance.
        wait_col(4'b0111, 40, n);
        keys[3][1] = 1'b1;
        repeat (8) @(negedge clk);
        keys[3] = '0;
        wait_col(4'b1110, 40, n);
        chk("short_adv", 32'(n + 8), 32'd12);
        chk("short_krow", 32'(k_row), 32'h0);

        // Two rows in one column pass through unchanged.
        wait_col(4'b1011, 40, n);
        keys[2] = 5'b01001;
        push_ev(1'b0, 5'b01001, 2'd2);
        wait_strobe(1'b0, 40, n);
        chk("multi_held", 32'(key_held), 32'd1);
        keys[2] = '0;
        push_ev(1'b1, 5'b0, 2'd0);
        wait_strobe(1'b1, 40, n);
        chk("multi_rel_col", 32'(col_out), 32'b0111);

        // Asynchronous reset while held on col3.
        keys[3] = 5'b10000;
        push_ev(1'b0, 5'b10000, 2'd3);
        wait_strobe(1'b0, 40, n);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_col", 32'(col_out), 32'hE);
        chk("arst_krow", 32'(k_row), 32'h0);
        chk("arst_held", 32'(key_held), 32'd0);
        chk("arst_rel", 32'(key_release), 32'd0);
        keys[3] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_col(4'b1101, 20, n);
        chk("resume", 32'(n), 32'd4);
        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
